// File: rtl/pe_mac_array.sv
// Signed multiply-accumulate PE: LANES products per beat, pipelined adder tree,
// and a saturating channel accumulator that folds first..last beats into one psum.
module pe_mac_array #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES*DW-1:0]     ifm_in,
    input  logic [LANES*DW-1:0]     wgt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_psum,
    output logic                    out_ovf
);
    localparam int LVLS = $clog2(LANES);

    logic out_valid_q;
    logic en;

    // The whole pipeline advances together; a held output freezes every stage.
    assign en       = !out_valid_q | out_ready;
    assign in_ready = en;

    // Saturating add: MSB of the result is the saturation flag, low ACC_W bits the clamped sum.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int N = LANES >> l;
        localparam int W = 2*DW + l;

        logic signed [W-1:0] val_d [N];
        logic signed [W-1:0] val_q [N];
        logic vld_d, vld_q, first_d, first_q, last_d, last_q;

        if (l == 0) begin : g_mul
            always_comb begin
                vld_d   = in_valid;
                first_d = in_first;
                last_d  = in_last;
                for (int i = 0; i < N; i++) begin
                    val_d[i] = W'($signed(ifm_in[i*DW +: DW])) * W'($signed(wgt_in[i*DW +: DW]));
                end
            end
        end else begin : g_add
            always_comb begin
                vld_d   = g_lvl[l-1].vld_q;
                first_d = g_lvl[l-1].first_q;
                last_d  = g_lvl[l-1].last_q;
                for (int i = 0; i < N; i++) begin
                    val_d[i] = W'(g_lvl[l-1].val_q[2*i]) + W'(g_lvl[l-1].val_q[2*i+1]);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (en) begin
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                val_q   <= val_d;
                first_q <= first_d;
                last_q  <= last_d;
            end
        end
    end

    // Accumulator stage
    logic signed [ACC_W-1:0] acc_d, acc_q, out_psum_d, out_psum_q, tree_ext, nacc;
    logic                    ovf_d, ovf_q, out_ovf_d, out_ovf_q, out_valid_d, novf;
    logic [ACC_W:0]          sat_res;

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_psum_d  = out_psum_q;
        out_ovf_d   = out_ovf_q;
        tree_ext    = ACC_W'(g_lvl[LVLS].val_q[0]);
        sat_res     = sat_add(acc_q, tree_ext);
        if (g_lvl[LVLS].first_q) begin
            nacc = tree_ext;
            novf = 1'b0;
        end else begin
            nacc = sat_res[ACC_W-1:0];
            novf = ovf_q | sat_res[ACC_W];
        end
        if (en) begin
            out_valid_d = 1'b0;
            if (g_lvl[LVLS].vld_q) begin
                if (g_lvl[LVLS].last_q) begin
                    out_valid_d = 1'b1;
                    out_psum_d  = nacc;
                    out_ovf_d   = novf;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d = nacc;
                    ovf_d = novf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_psum_q  <= out_psum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_psum  = out_psum_q;
    assign out_ovf   = out_ovf_q;
endmodule
